// File: rtl/gt_input_unit.sv
// gt_input_unit: serial pads + PS/2 keyboard capture into the Gigatron IN byte; define GT_INPUT_PARITY_EN to reject bad-parity frames
module gt_input_unit #(
  parameter int NUM_PADS    = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_FRAMES = 2,
  parameter int TIMEOUT_CYC = 4096,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_PADS-1:0]           SER_DATA,
  input  logic                          HSYNC,
  input  logic                          VSYNC,
  input  logic                          KBCLK,
  input  logic                          KBDTA,
  output logic [7:0]                    IN_DATA,
  output logic                          KEY_ACTIVE,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          OVF,
  output logic [7:0]                    PAR_ERR_CNT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = NUM_PADS + 4;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  typedef enum logic [1:0] {K_IDLE, K_DATA, K_PARITY, K_STOP} kb_state_t;
  typedef enum logic {P_PAD, P_KEY} pres_state_t;
  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] sync_d [SYNC_STAGES];
  logic [SW-1:0] prev_q, prev_d, s;
  logic [7:0] sr_q [NUM_PADS];
  logic [7:0] sr_d [NUM_PADS];
  logic [7:0] pad_q [NUM_PADS];
  logic [7:0] pad_d [NUM_PADS];
  kb_state_t kb_q, kb_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shf_q, shf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic push_q, push_d;
  logic [7:0] push_byte_q, push_byte_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic ovf_q, ovf_d;
  pres_state_t pres_q, pres_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0] key_q, key_d, in_q, in_d, merged;
  logic act_q, act_d;
  logic hs_rise, vs_rise, kb_fall, kb_bit, tmo, ok, pop, push_ok;
`ifdef GT_INPUT_PARITY_EN
  logic par_q, par_d;
  logic [7:0] perr_q, perr_d;
`endif
  assign s = sync_q[SYNC_STAGES-1];
  // next-state logic: synchronisers, pad shifters, PS/2 receiver, FIFO and frame presenter
  always_comb begin
    sync_d[0] = {KBDTA, KBCLK, VSYNC, HSYNC, SER_DATA};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = s;
    hs_rise = s[NUM_PADS] & ~prev_q[NUM_PADS];
    vs_rise = s[NUM_PADS+1] & ~prev_q[NUM_PADS+1];
    kb_fall = ~s[NUM_PADS+2] & prev_q[NUM_PADS+2];
    kb_bit = s[NUM_PADS+3];
    merged = 8'hFF;
    for (int i = 0; i < NUM_PADS; i++) begin
      sr_d[i] = hs_rise ? {sr_q[i][6:0], s[i]} : sr_q[i];
      pad_d[i] = vs_rise ? sr_q[i] : pad_q[i];
      merged = merged & pad_d[i];
    end
`ifdef GT_INPUT_PARITY_EN
    ok = par_q;
    par_d = !kb_fall ? par_q : kb_q == K_IDLE ? 1'b0 : par_q ^ kb_bit;
    perr_d = (kb_fall && kb_q == K_STOP && !par_q && perr_q != 8'hFF) ? perr_q + 8'd1 : perr_q;
`else
    ok = 1'b1;
`endif
    kb_d = kb_q;
    bit_d = bit_q;
    shf_d = shf_q;
    push_d = 1'b0;
    push_byte_d = push_byte_q;
    tmo_d = kb_fall ? '0 : (tmo_q == TW'(TIMEOUT_CYC) ? tmo_q : tmo_q + 1'b1);
    tmo = kb_q != K_IDLE && tmo_q == TW'(TIMEOUT_CYC);
    if (kb_fall) begin
      case (kb_q)
        K_IDLE: begin
          kb_d = kb_bit ? K_IDLE : K_DATA;
          bit_d = 3'd0;
        end
        K_DATA: begin
          shf_d = {kb_bit, shf_q[7:1]};
          bit_d = bit_q + 3'd1;
          kb_d = bit_q == 3'd7 ? K_PARITY : K_DATA;
        end
        K_PARITY: kb_d = K_STOP;
        K_STOP: begin
          kb_d = K_IDLE;
          push_d = kb_bit & ok;
          push_byte_d = shf_q;
        end
      endcase
    end else if (tmo) kb_d = K_IDLE;
    pop = 1'b0;
    pres_d = pres_q;
    hold_d = hold_q;
    key_d = key_q;
    if (vs_rise) begin
      if (pres_q == P_PAD || hold_q == HW'(1)) begin
        pop = lvl_q != '0;
        pres_d = pop ? P_KEY : P_PAD;
        hold_d = pop ? HW'(HOLD_FRAMES) : '0;
        key_d = pop ? mem_q[rd_q] : key_q;
      end else hold_d = hold_q - 1'b1;
    end
    push_ok = push_q && lvl_q != LW'(FIFO_DEPTH);
    ovf_d = ovf_q | (push_q & ~push_ok);
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = push_byte_q;
    wr_d = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    lvl_d = lvl_q + LW'(push_ok) - LW'(pop);
    in_d = pres_d == P_KEY ? key_d : merged;
    act_d = pres_d == P_KEY;
  end
  // state registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '{default: '1};
      prev_q <= '1;
      sr_q <= '{default: 8'hFF};
      pad_q <= '{default: 8'hFF};
      kb_q <= K_IDLE;
      bit_q <= 3'd0;
      shf_q <= 8'h00;
      tmo_q <= '0;
      push_q <= 1'b0;
      push_byte_q <= 8'h00;
      mem_q <= '{default: 8'h00};
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      pres_q <= P_PAD;
      hold_q <= '0;
      key_q <= 8'hFF;
      in_q <= 8'hFF;
      act_q <= 1'b0;
`ifdef GT_INPUT_PARITY_EN
      par_q <= 1'b0;
      perr_q <= 8'h00;
`endif
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      sr_q <= sr_d;
      pad_q <= pad_d;
      kb_q <= kb_d;
      bit_q <= bit_d;
      shf_q <= shf_d;
      tmo_q <= tmo_d;
      push_q <= push_d;
      push_byte_q <= push_byte_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
      pres_q <= pres_d;
      hold_q <= hold_d;
      key_q <= key_d;
      in_q <= in_d;
      act_q <= act_d;
`ifdef GT_INPUT_PARITY_EN
      par_q <= par_d;
      perr_q <= perr_d;
`endif
    end
  end
  assign IN_DATA = in_q;
  assign KEY_ACTIVE = act_q;
  assign FIFO_LEVEL = lvl_q;
  assign OVF = ovf_q;
`ifdef GT_INPUT_PARITY_EN
  assign PAR_ERR_CNT = perr_q;
`else
  assign PAR_ERR_CNT = 8'h00;
`endif
endmodule
